opcode_exec: RTL and testbench

OPCODE_EXEC -- requirements
Module: opcode_exec

---
 rtl/opcode_exec_pkg.sv | 25 ++
 rtl/opcode_exec_muldiv.sv | 86 ++++++++
 rtl/opcode_exec.sv | 123 ++++++++++++
 tb/tb_opcode_exec.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/opcode_exec_pkg.sv
// Shared constants and types for the opcode executor.
// The divider is only built when OPCODE_EXEC_DIV_EN is defined.
package opcode_exec_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_MUL = 8'h03;
  localparam logic [7:0] OP_DIV = 8'h04;
  localparam logic [7:0] OP_AND = 8'h05;
  localparam logic [7:0] OP_OR  = 8'h06;
  localparam logic [7:0] OP_XOR = 8'h07;

  localparam logic [7:0] ERR_BYTE = 8'hFF;

  localparam int unsigned ITER = 8;
  localparam logic [2:0] ITER_LAST = 3'(ITER - 1);

endpackage

// File: rtl/opcode_exec_muldiv.sv
// Iterative shift-add multiplier and (with OPCODE_EXEC_DIV_EN)
// restoring divider; one step per cycle for ITER cycles.
module opcode_exec_muldiv
  import opcode_exec_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       div_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       done_o,
  output logic [7:0] byte0_o,
  output logic [7:0] byte1_o
);

  logic       run_q;
  logic [2:0] cnt_q;
  logic [7:0] op_q;
  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;
  logic [8:0] msum;
  logic       load;

`ifdef OPCODE_EXEC_DIV_EN
  logic       div_q;
  logic [8:0] shl;
  logic       ge;

  assign load    = start_i;
  assign byte0_o = div_q ? lo_q : hi_q;
  assign byte1_o = div_q ? hi_q : lo_q;
`else
  assign load    = start_i & ~div_i;
  assign byte0_o = hi_q;
  assign byte1_o = lo_q;
`endif

  assign done_o = run_q && (cnt_q == ITER_LAST);

  // hi:lo is the product register (mul) or remainder:quotient (div)
  always_comb begin
    msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : 9'd0);
    hi_d = msum[8:1];
    lo_d = {msum[0], lo_q[7:1]};
`ifdef OPCODE_EXEC_DIV_EN
    shl = {hi_q, lo_q[7]};
    ge  = shl >= {1'b0, op_q};
    if (div_q) begin
      hi_d = ge ? (shl[7:0] - op_q) : shl[7:0];
      lo_d = {lo_q[6:0], ge};
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
`ifdef OPCODE_EXEC_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (load) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      hi_q  <= '0;
`ifdef OPCODE_EXEC_DIV_EN
      div_q <= div_i;
      op_q  <= div_i ? b_i : a_i;
      lo_q  <= div_i ? a_i : b_i;
`else
      op_q  <= a_i;
      lo_q  <= b_i;
`endif
    end else if (run_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == ITER_LAST) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/opcode_exec.sv
// Opcode executor: latches operands, computes, streams result bytes
// to a UART. Divide support is gated by OPCODE_EXEC_DIV_EN.
module opcode_exec
  import opcode_exec_pkg::*;
(
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_num_1,
  input  logic [7:0] i_num_2,
  input  logic [7:0] i_opcode,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic       o_busy,
  output logic       o_error,
  output logic       o_overrun
);

  state_e     state_q;
  logic [7:0] a_q, b_q, op_q, res_q, tx_data_q;
  logic       md_q, pend_q, tx_start_q, err_q, ovr_q;
  logic       md_start, md_div, md_done, div_ok;
  logic [7:0] md_b0, md_b1, alu_res, send_byte;
  logic       alu_ok;

`ifdef OPCODE_EXEC_DIV_EN
  assign div_ok = (i_opcode == OP_DIV) && (i_num_2 != 8'd0);
`else
  assign div_ok = 1'b0;
`endif

  assign md_div   = (i_opcode == OP_DIV);
  assign md_start = (state_q == S_IDLE) && i_start &&
                    ((i_opcode == OP_MUL) || div_ok);

  opcode_exec_muldiv u_muldiv (
    .clk_i   (i_clk),
    .rst_i   (reset),
    .start_i (md_start),
    .div_i   (md_div),
    .a_i     (i_num_1),
    .b_i     (i_num_2),
    .done_o  (md_done),
    .byte0_o (md_b0),
    .byte1_o (md_b1)
  );

  // DIV by zero and DIV without the divider fall to the error byte
  always_comb begin
    alu_res = ERR_BYTE;
    alu_ok  = 1'b1;
    unique case (1'b1)
      (op_q == OP_ADD): alu_res = a_q + b_q;
      (op_q == OP_SUB): alu_res = a_q - b_q;
      (op_q == OP_AND): alu_res = a_q & b_q;
      (op_q == OP_OR):  alu_res = a_q | b_q;
      (op_q == OP_XOR): alu_res = a_q ^ b_q;
      default:          alu_ok  = 1'b0;
    endcase
  end

  assign send_byte = md_q ? (pend_q ? md_b0 : md_b1) : res_q;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      md_q       <= 1'b0;
      pend_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      if (i_start && (state_q != S_IDLE)) ovr_q <= 1'b1;
      case (state_q)
        S_IDLE: if (i_start) begin
          a_q     <= i_num_1;
          b_q     <= i_num_2;
          op_q    <= i_opcode;
          md_q    <= md_start;
          state_q <= S_EXEC;
        end
        S_EXEC: if (md_q) begin
          if (md_done) begin
            pend_q  <= 1'b1;
            state_q <= S_SEND;
          end
        end else begin
          res_q   <= alu_res;
          err_q   <= ~alu_ok;
          pend_q  <= 1'b0;
          state_q <= S_SEND;
        end
        S_SEND: if (!i_tx_busy) begin
          tx_data_q  <= send_byte;
          tx_start_q <= 1'b1;
          state_q    <= S_GAP;
        end
        S_GAP: if (pend_q) begin
          pend_q  <= 1'b0;
          state_q <= S_SEND;
        end else begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_error    = err_q;
  assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_opcode_exec.sv
// Self-checking bench for opcode_exec: vector table plus a byte
// scoreboard, and hand sequences for reset corner cases.
module tb_opcode_exec;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic [7:0] i_num_1, i_num_2, i_opcode;
  logic       i_tx_busy;
  logic [7:0] o_tx_data;
  logic       o_tx_start, o_busy, o_error, o_overrun;

  always #5 clk = ~clk;

  opcode_exec dut (
    .i_clk      (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_num_1    (i_num_1),
    .i_num_2    (i_num_2),
    .i_opcode   (i_opcode),
    .i_tx_busy  (i_tx_busy),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_busy     (o_busy),
    .o_error    (o_error),
    .o_overrun  (o_overrun)
  );

  typedef struct {
    string      nm;
    logic [7:0] op, a, b;
    int         nb;
    logic [7:0] e0, e1;
    int         lat;
    int         err;
    int         busy_until;
    int         ovr_at;
  } vec_t;

  vec_t       vt[$];
  logic [7:0] sb[$];
  logic       exp_ovr = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [7:0] op,
                              input logic [7:0] a, input logic [7:0] b,
                              input int nb, input logic [7:0] e0,
                              input logic [7:0] e1, input int lat,
                              input int err, input int bu, input int ov);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.nb = nb;
    v.e0 = e0; v.e1 = e1; v.lat = lat; v.err = err;
    v.busy_until = bu; v.ovr_at = ov;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int np = 0;
    int first = -1;
    int second = -1;
    int nerr = 0;
    int cyc;
    logic [7:0] e;
    logic [7:0] last;
    @(negedge clk);
    i_start = 1'b1; i_opcode = v.op; i_num_1 = v.a; i_num_2 = v.b;
    i_tx_busy = (v.busy_until > 0);
    sb.push_back(v.e0);
    last = v.e0;
    if (v.nb == 2) begin
      sb.push_back(v.e1);
      last = v.e1;
    end
    @(negedge clk);
    for (cyc = 0; cyc < 100; cyc++) begin
      i_start   = (v.ovr_at != 0) && (cyc == v.ovr_at);
      i_opcode  = i_start ? 8'h01 : 8'($urandom);
      i_num_1   = 8'($urandom);
      i_num_2   = 8'($urandom);
      i_tx_busy = (cyc < v.busy_until);
      if (o_tx_start) begin
        if (sb.size() == 0) begin
          chk({v.nm, " extra pulse"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({v.nm, " data"}, {24'd0, o_tx_data}, {24'd0, e});
        end
        if (np == 0) first = cyc;
        else if (np == 1) second = cyc;
        np++;
      end
      if (o_error) nerr++;
      if (cyc > 0 && !o_busy) break;
      @(negedge clk);
    end
    i_start = 1'b0;
    i_tx_busy = 1'b0;
    if (cyc >= 100) chk({v.nm, " timeout"}, 32'd1, 32'd0);
    if (v.ovr_at != 0) exp_ovr = 1'b1;
    chk({v.nm, " pulses"}, np, v.nb);
    chk({v.nm, " latency"}, first, v.lat);
    if (v.nb == 2) chk({v.nm, " gap"}, 32'(second - first >= 2), 32'd1);
    chk({v.nm, " error"}, nerr, v.err);
    chk({v.nm, " overrun"}, {31'd0, o_overrun}, {31'd0, exp_ovr});
    chk({v.nm, " hold"}, {24'd0, o_tx_data}, {24'd0, last});
    sb.delete();
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " busy"}, {31'd0, o_busy}, 32'd0);
    chk({nm, " tx_data"}, {24'd0, o_tx_data}, 32'd0);
    chk({nm, " tx_start"}, {31'd0, o_tx_start}, 32'd0);
    chk({nm, " error"}, {31'd0, o_error}, 32'd0);
    chk({nm, " overrun"}, {31'd0, o_overrun}, 32'd0);
  endtask

  task automatic quiet(input string nm, input int n);
    int np = 0;
    int ne = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_tx_start) np++;
      if (o_error) ne++;
    end
    chk({nm, " no pulse"}, np, 0);
    chk({nm, " no error"}, ne, 0);
  endtask

  initial begin
    reset = 1'b1; i_start = 1'b0; i_tx_busy = 1'b0;
    i_num_1 = 8'h00; i_num_2 = 8'h00; i_opcode = 8'h00;

    vt.push_back(mk("add", 8'h01, 8'hF0, 8'h20, 1, 8'h10, 8'h00, 2, 0, 0, 0));
    vt.push_back(mk("sub", 8'h02, 8'h10, 8'h20, 1, 8'hF0, 8'h00, 2, 0, 0, 0));
    vt.push_back(mk("and", 8'h05, 8'hCC, 8'hAA, 1, 8'h88, 8'h00, 2, 0, 0, 0));
    vt.push_back(mk("or",  8'h06, 8'hCC, 8'hAA, 1, 8'hEE, 8'h00, 2, 0, 0, 0));
    vt.push_back(mk("xor", 8'h07, 8'hCC, 8'hAA, 1, 8'h66, 8'h00, 2, 0, 0, 0));
    vt.push_back(mk("mul_ff", 8'h03, 8'hFF, 8'hFF, 2, 8'hFE, 8'h01, 9, 0, 0, 0));
    vt.push_back(mk("mul_small", 8'h03, 8'h0D, 8'h0B, 2, 8'h00, 8'h8F, 9, 0, 0, 0));
`ifdef OPCODE_EXEC_DIV_EN
    vt.push_back(mk("div_100_7", 8'h04, 8'd100, 8'd7, 2, 8'h0E, 8'h02, 9, 0, 0, 0));
    vt.push_back(mk("div_255_16", 8'h04, 8'd255, 8'd16, 2, 8'h0F, 8'h0F, 9, 0, 0, 0));
`else
    vt.push_back(mk("div_off", 8'h04, 8'd100, 8'd7, 1, 8'hFF, 8'h00, 2, 1, 0, 0));
`endif
    vt.push_back(mk("div_zero", 8'h04, 8'd5, 8'd0, 1, 8'hFF, 8'h00, 2, 1, 0, 0));
    vt.push_back(mk("op_09", 8'h09, 8'h12, 8'h34, 1, 8'hFF, 8'h00, 2, 1, 0, 0));
    vt.push_back(mk("op_00", 8'h00, 8'h12, 8'h34, 1, 8'hFF, 8'h00, 2, 1, 0, 0));
    vt.push_back(mk("tx_busy", 8'h01, 8'h07, 8'h08, 1, 8'h0F, 8'h00, 23, 0, 22, 0));
    vt.push_back(mk("mul_ovr", 8'h03, 8'h12, 8'h34, 2, 8'h03, 8'hA8, 9, 0, 0, 3));

    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    foreach (vt[i]) run_vec(vt[i]);

    // Reset in the 4th EXEC cycle of a multiply
    @(negedge clk);
    i_start = 1'b1; i_opcode = 8'h03; i_num_1 = 8'hFF; i_num_2 = 8'hFF;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_ovr = 1'b0;
    chk_idle("mid_reset");
    reset = 1'b0;
    quiet("mid_reset", 20);

    // Reset together with start drops the start
    @(negedge clk);
    reset = 1'b1; i_start = 1'b1; i_opcode = 8'h01;
    i_num_1 = 8'h11; i_num_2 = 8'h22;
    @(negedge clk);
    reset = 1'b0; i_start = 1'b0;
    chk("rst_start busy", {31'd0, o_busy}, 32'd0);
    quiet("rst_start", 10);

    run_vec(mk("add_after", 8'h01, 8'h11, 8'h22, 1, 8'h33, 8'h00, 2, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
